// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state type for the sequencing ALU
package alu_pkg;

   // ALU_op classes from the main decoder
   localparam int OP_ADD     = 0;
   localparam int OP_SUB     = 1;
   localparam int OP_RTYPE   = 2;
   localparam int OP_ILLEGAL = 3;

   // R-type funct values
   localparam int FN_LUI   = 15;
   localparam int FN_MFHI  = 16;
   localparam int FN_MFLO  = 18;
   localparam int FN_MULTU = 25;
   localparam int FN_DIVU  = 27;
   localparam int FN_ADD   = 32;
   localparam int FN_SUB   = 34;
   localparam int FN_AND   = 36;
   localparam int FN_OR    = 37;
   localparam int FN_NOR   = 39;
   localparam int FN_SLT   = 42;

   // Decoded control codes
   localparam int CTRL_AND     = 0;
   localparam int CTRL_OR      = 1;
   localparam int CTRL_ADD     = 2;
   localparam int CTRL_SUB     = 6;
   localparam int CTRL_SLT     = 7;
   localparam int CTRL_LUI     = 8;
   localparam int CTRL_MFHI    = 9;
   localparam int CTRL_MFLO    = 10;
   localparam int CTRL_MULTU   = 11;
   localparam int CTRL_NOR     = 12;
   localparam int CTRL_DIVU    = 13;
   localparam int CTRL_ILLEGAL = 15;

   typedef enum logic {
      IDLE = 1'b0,
      ITER = 1'b1
   } iter_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier / restoring divider owning HI and LO
// The divide path exists only when ALU_DIV_EN is defined.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic [DATA_WIDTH-1:0] lo_next
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   iter_state_e state, state_nx;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] opnd;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] qr;
   logic [DATA_WIDTH-1:0] acc_nx;
   logic [DATA_WIDTH-1:0] qr_nx;
   logic [DATA_WIDTH:0]   sum;

`ifdef ALU_DIV_EN
   logic                  is_div;
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
`else
   logic                  unused_mode;
   assign unused_mode = mode;
`endif

   assign busy    = (state == ITER);
   assign done    = busy && (cnt == LAST);
   assign lo_next = qr_nx;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ITER;
         ITER:    if (cnt == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // {acc,qr} is the product/remainder-quotient pair; opnd is multiplicand or divisor
   always_comb begin
      acc_nx = acc;
      qr_nx  = qr;
      sum    = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
`ifdef ALU_DIV_EN
      shifted = {acc, qr[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (is_div) begin
         if (!diff[DATA_WIDTH]) begin
            acc_nx = diff[DATA_WIDTH-1:0];
            qr_nx  = {qr[DATA_WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = shifted[DATA_WIDTH-1:0];
            qr_nx  = {qr[DATA_WIDTH-2:0], 1'b0};
         end
      end else
`endif
      begin
         acc_nx = sum[DATA_WIDTH:1];
         qr_nx  = {sum[0], qr[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         opnd <= '0;
         acc  <= '0;
         qr   <= '0;
         hi   <= '0;
         lo   <= '0;
`ifdef ALU_DIV_EN
         is_div <= 1'b0;
`endif
      end else if (start && !busy) begin
         // a*b is symmetric, so both modes load op_a into qr and op_b into opnd
         cnt  <= '0;
         opnd <= op_b;
         acc  <= '0;
         qr   <= op_a;
`ifdef ALU_DIV_EN
         is_div <= mode;
`endif
      end else if (busy) begin
         acc <= acc_nx;
         qr  <= qr_nx;
         cnt <= cnt + 1'b1;
         if (done) begin
            hi <= acc_nx;
            lo <= qr_nx;
         end
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - EX-stage ALU: decode, single-cycle ops, registered result, iterative MULTU
// Defining ALU_DIV_EN adds DIVU (funct 27) through the iterative engine.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int ALU_OP_SIZE        = 2,
   parameter int FUNCTION_CODE_SIZE = 6,
   parameter int ALU_CTRL_SIZE      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ALU_OP_SIZE-1:0]        ALU_op,
   input  logic [FUNCTION_CODE_SIZE-1:0] function_code,
   input  logic [DATA_WIDTH-1:0]         operand_a,
   input  logic [DATA_WIDTH-1:0]         operand_b,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         result,
   output logic                          zero,
   output logic [ALU_CTRL_SIZE-1:0]      ALU_ctrl,
   output logic                          illegal
);

   logic [ALU_CTRL_SIZE-1:0] dec_ctrl;
   logic [ALU_CTRL_SIZE-1:0] iter_ctrl;
   logic                     dec_illegal;
   logic                     dec_iter;
   logic                     dec_div;
   logic [DATA_WIDTH-1:0]    alu_res;
   logic                     accept;
   logic                     eng_busy;
   logic                     eng_done;
   logic [DATA_WIDTH-1:0]    hi;
   logic [DATA_WIDTH-1:0]    lo;
   logic [DATA_WIDTH-1:0]    lo_next;

   assign in_ready = !eng_busy;
   assign accept   = in_valid && in_ready;
   assign zero     = (result == '0);

   always_comb begin
      dec_ctrl    = ALU_CTRL_SIZE'(CTRL_ILLEGAL);
      dec_illegal = 1'b1;
      dec_iter    = 1'b0;
      dec_div     = 1'b0;
      case (int'(ALU_op))
         OP_ADD: begin dec_ctrl = ALU_CTRL_SIZE'(CTRL_ADD); dec_illegal = 1'b0; end
         OP_SUB: begin dec_ctrl = ALU_CTRL_SIZE'(CTRL_SUB); dec_illegal = 1'b0; end
         OP_RTYPE: begin
            dec_illegal = 1'b0;
            case (int'(function_code))
               FN_LUI:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_LUI);
               FN_ADD:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_ADD);
               FN_SUB:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_SUB);
               FN_AND:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_AND);
               FN_OR:    dec_ctrl = ALU_CTRL_SIZE'(CTRL_OR);
               FN_NOR:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_NOR);
               FN_SLT:   dec_ctrl = ALU_CTRL_SIZE'(CTRL_SLT);
               FN_MFHI:  dec_ctrl = ALU_CTRL_SIZE'(CTRL_MFHI);
               FN_MFLO:  dec_ctrl = ALU_CTRL_SIZE'(CTRL_MFLO);
               FN_MULTU: begin dec_ctrl = ALU_CTRL_SIZE'(CTRL_MULTU); dec_iter = 1'b1; end
`ifdef ALU_DIV_EN
               FN_DIVU:  begin
                  dec_ctrl = ALU_CTRL_SIZE'(CTRL_DIVU);
                  dec_iter = 1'b1;
                  dec_div  = 1'b1;
               end
`endif
               default:  dec_illegal = 1'b1;
            endcase
         end
         OP_ILLEGAL: dec_illegal = 1'b1;
         default:    dec_illegal = 1'b1;
      endcase
   end

   // Illegal and iterative codes fall to the default and yield 0 here
   always_comb begin
      alu_res = '0;
      case (int'(dec_ctrl))
         CTRL_AND:  alu_res = operand_a & operand_b;
         CTRL_OR:   alu_res = operand_a | operand_b;
         CTRL_NOR:  alu_res = ~(operand_a | operand_b);
         CTRL_ADD:  alu_res = operand_a + operand_b;
         CTRL_SUB:  alu_res = operand_a - operand_b;
         CTRL_SLT:  alu_res = DATA_WIDTH'($signed(operand_a) < $signed(operand_b));
         CTRL_LUI:  alu_res = operand_b << (DATA_WIDTH / 2);
         CTRL_MFHI: alu_res = hi;
         CTRL_MFLO: alu_res = lo;
         default:   alu_res = '0;
      endcase
   end

   alu_iter_muldiv #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && dec_iter),
      .mode    (dec_div),
      .op_a    (operand_a),
      .op_b    (operand_b),
      .busy    (eng_busy),
      .done    (eng_done),
      .hi      (hi),
      .lo      (lo),
      .lo_next (lo_next)
   );

   // Engine completion and a single-cycle accept never coincide: in_ready is low while busy
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         ALU_ctrl  <= '0;
         illegal   <= 1'b0;
         iter_ctrl <= '0;
      end else begin
         out_valid <= 1'b0;
         if (eng_done) begin
            out_valid <= 1'b1;
            result    <= lo_next;
            ALU_ctrl  <= iter_ctrl;
            illegal   <= 1'b0;
         end else if (accept && !dec_iter) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            ALU_ctrl  <= dec_ctrl;
            illegal   <= dec_illegal;
         end
         if (accept && dec_iter) iter_ctrl <= dec_ctrl;
      end
   end

endmodule
